// File: rtl/rbzero_spi_tx.sv
`timescale 1ns/1ps
// rbzero_spi_tx: SPI mode-0 controller that shifts out a left-aligned frame
// of 1..MAX_BITS bits MSB-first, framed by ss_n. Every output is a flop.
//
// state | meaning
// IDLE  | ready for a request, ss_n high
// SETUP | ss_n low, first bit presented before the first rising SCLK
// HIGH  | SCLK high, receiver samples on the rising edge
// LOW   | SCLK low, next bit presented
// HOLD  | SCLK low after the last bit, ss_n still low
// GAP   | ss_n high for the minimum inter-frame gap, done on first cycle
module rbzero_spi_tx #(
   parameter int MAX_BITS   = 80,
   parameter int HALF_DIV   = 2,
   parameter int GAP_HALVES = 2,
   parameter int LW         = $clog2(MAX_BITS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [LW-1:0]       i_len,
   input  logic [MAX_BITS-1:0] i_data,
   output logic                o_ready,
   output logic                o_done,
   output logic                o_sclk,
   output logic                o_mosi,
   output logic                o_ss_n
);

   localparam int TW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(HALF_DIV - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_HALVES - 1);
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BITS);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, LOW, HOLD, GAP
   } state_t;

   state_t              state_q;
   logic [MAX_BITS-1:0] shift_q;
   logic [LW-1:0]       cnt_q;
   logic [TW-1:0]       tmr_q;
   logic [GW-1:0]       gap_q;
   logic                ready_q, done_q, sclk_q, mosi_q, ss_n_q;

   logic len_ok;
   logic half_end;

   assign len_ok   = (i_len != '0) && (i_len <= LEN_MAX);
   assign half_end = (tmr_q == T_LAST);

   // Frame sequencer: half-period timer, shift register, bit counter and
   // all outputs are updated together so every output comes from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         gap_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         ss_n_q  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE || half_end) tmr_q <= '0;
         else                             tmr_q <= tmr_q + 1'b1;

         case (state_q)
            IDLE: begin
               if (i_start && len_ok) begin
                  shift_q <= i_data;
                  cnt_q   <= i_len;
                  ss_n_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  mosi_q  <= i_data[MAX_BITS-1];
                  ready_q <= 1'b0;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (half_end) begin
                  sclk_q  <= 1'b1;
                  state_q <= HIGH;
               end
            end
            HIGH: begin
               if (half_end) begin
                  sclk_q <= 1'b0;
                  if (cnt_q == LW'(1)) begin
                     state_q <= HOLD;
                  end else begin
                     // Falling SCLK and the next bit change on the same edge,
                     // leaving a full half period of setup before sampling.
                     shift_q <= {shift_q[MAX_BITS-2:0], 1'b0};
                     mosi_q  <= shift_q[MAX_BITS-2];
                     cnt_q   <= cnt_q - 1'b1;
                     state_q <= LOW;
                  end
               end
            end
            LOW: begin
               if (half_end) begin
                  sclk_q  <= 1'b1;
                  state_q <= HIGH;
               end
            end
            HOLD: begin
               if (half_end) begin
                  ss_n_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  done_q  <= 1'b1;
                  gap_q   <= G_LAST;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (half_end) begin
                  if (gap_q == '0) begin
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     gap_q <= gap_q - 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               ss_n_q  <= 1'b1;
               sclk_q  <= 1'b0;
               mosi_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_done  = done_q;
   assign o_sclk  = sclk_q;
   assign o_mosi  = mosi_q;
   assign o_ss_n  = ss_n_q;

endmodule
